// File: rtl/code_decoder_sequencer.sv
// Queues 2-bit codes in a small FIFO and replays each one as a
// one-hot output held for a fixed number of cycles.
module code_decoder_sequencer #(
    parameter int N_OUT       = 3,
    parameter int HOLD_CYCLES = 4,
    parameter int DEPTH       = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [1:0]               in_code,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     clear_err,
    output logic [N_OUT-1:0]         onehot,
    output logic                     active,
    output logic                     done_pulse,
    output logic                     err_illegal,
    output logic [7:0]               err_count,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int AW       = $clog2(DEPTH);
    localparam int HOLD_EFF = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
    localparam logic [7:0]  HOLD_LOAD = 8'(HOLD_EFF - 1);
    localparam logic [AW:0] FULL      = (AW + 1)'(DEPTH);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [N_OUT-1:0] onehot_q;
    logic [N_OUT-1:0] onehot_d;
    logic [7:0]       cnt_q;
    logic [7:0]       cnt_d;

    logic [1:0]       mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      level_q;

    logic             xfer;
    logic             legal;
    logic             push;
    logic             pop;
    logic             empty;
    logic             bad_xfer;
    logic [N_OUT-1:0] head_dec;

    assign in_ready   = (level_q < FULL);
    assign empty      = (level_q == '0);
    assign xfer       = in_valid && in_ready;
    assign legal      = ({30'd0, in_code} < 32'(N_OUT));
    assign push       = xfer && legal;
    assign bad_xfer   = xfer && !legal;
    assign head_dec   = N_OUT'(1) << mem[rd_ptr];

    assign onehot     = onehot_q;
    assign active     = (state_q == HOLD);
    assign fifo_level = level_q;

    // FIFO storage; only legal codes are ever written
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= in_code;
        end
    end

    // FIFO pointers and occupancy, wrapping modulo DEPTH
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Sequencer state, one-hot output and hold counter registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            onehot_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            onehot_q <= onehot_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state: pop the head when idle or at the end of a hold
    always_comb begin
        state_d    = state_q;
        onehot_d   = onehot_q;
        cnt_d      = cnt_q;
        pop        = 1'b0;
        done_pulse = 1'b0;
        case (state_q)
            IDLE: begin
                onehot_d = '0;
                if (!empty) begin
                    pop      = 1'b1;
                    onehot_d = head_dec;
                    cnt_d    = HOLD_LOAD;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    done_pulse = 1'b1;
                    if (!empty) begin
                        pop      = 1'b1;
                        onehot_d = head_dec;
                        cnt_d    = HOLD_LOAD;
                    end else begin
                        onehot_d = '0;
                        state_d  = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sticky illegal-code flag and saturating counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_illegal <= 1'b0;
            err_count   <= 8'd0;
        end else if (clear_err) begin
            err_illegal <= bad_xfer;
            err_count   <= bad_xfer ? 8'd1 : 8'd0;
        end else if (bad_xfer) begin
            err_illegal <= 1'b1;
            if (err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule
